// File: rtl/out_writeback.sv
// Writeback stage behind the output sequencer: adds per-channel bias, shifts, clamps and
// writes results into the dst buffer, counting writes to flag the end of each job.
module out_writeback #(
    parameter int AW = 24,
    parameter int BW = 16,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          outr,
    input  logic [3:0]    ra,
    input  logic [11:0]   oa,
    input  logic [AW-1:0] acc_d,
    input  logic          bias_we,
    input  logic [3:0]    bias_a,
    input  logic [BW-1:0] bias_d,
    input  logic          relu,
    input  logic [3:0]    shift,
    input  logic [3:0]    od,
    input  logic [9:0]    os,
    output logic          dst_we,
    output logic [11:0]   dst_wa,
    output logic [OW-1:0] dst_wd,
    output logic          busy,
    output logic          done
);

    localparam logic signed [AW:0] SAT_HI = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] SAT_LO = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    logic [BW-1:0]     bias_q [16];

    logic              v1;
    logic [3:0]        ra1;
    logic [11:0]       oa1;

    logic              v2;
    logic [11:0]       oa2;
    logic signed [AW:0] sum;

    logic [13:0]       cnt;

    logic [BW-1:0]     bias_sel;
    logic signed [AW:0] acc_ext;
    logic signed [AW:0] bias_ext;
    logic signed [AW:0] sum_c;
    logic signed [AW:0] sh_c;
    logic [OW-1:0]     wd_c;
    logic [13:0]       total_c;
    logic [13:0]       cnt_inc;
    logic              last_c;
    logic [13:0]       cnt_nxt;

    // Stage 1: bias read is combinational, so a same-cycle write lands after this read.
    always_comb begin
        bias_sel = bias_q[ra1];
        acc_ext  = {acc_d[AW-1], acc_d};
        bias_ext = {{(AW+1-BW){bias_sel[BW-1]}}, bias_sel};
        sum_c    = acc_ext + bias_ext;
    end

    // Stage 2: floor shift, optional ReLU, then clamp into the output range.
    always_comb begin
        sh_c = sum >>> shift;
        if (relu && sh_c[AW]) begin
            sh_c = '0;
        end
        if (sh_c > SAT_HI) begin
            wd_c = {1'b0, {(OW-1){1'b1}}};
        end else if (sh_c < SAT_LO) begin
            wd_c = {1'b1, {(OW-1){1'b0}}};
        end else begin
            wd_c = sh_c[OW-1:0];
        end
    end

    // A zero-sized job (os=0) must never complete, so total=0 is excluded from the match.
    always_comb begin
        total_c = ({10'd0, od} + 14'd1) * {4'd0, os};
        cnt_inc = cnt + 14'd1;
        last_c  = dst_we && (total_c != 14'd0) && (cnt_inc == total_c);
        cnt_nxt = cnt;
        if (dst_we) begin
            cnt_nxt = last_c ? 14'd0 : cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                bias_q[i] <= '0;
            end
            v1     <= 1'b0;
            ra1    <= '0;
            oa1    <= '0;
            v2     <= 1'b0;
            oa2    <= '0;
            sum    <= '0;
            dst_we <= 1'b0;
            dst_wa <= '0;
            dst_wd <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (bias_we) begin
                bias_q[bias_a] <= bias_d;
            end

            v1  <= outr;
            ra1 <= ra;
            oa1 <= oa;

            v2  <= v1;
            oa2 <= oa1;
            sum <= sum_c;

            dst_we <= v2;
            if (v2) begin
                dst_wa <= oa2;
                dst_wd <= wd_c;
            end

            cnt  <= cnt_nxt;
            done <= last_c;
            // Next-state form of (cnt!=0)|v1|v2 so busy lines up with those registers.
            busy <= (cnt_nxt != 14'd0) | outr | v1;
        end
    end

endmodule

// File: tb/tb_out_writeback.sv
// Directed bench for out_writeback: scoreboard of expected writes keyed by due cycle,
// plus a reference model of the bias/shift/ReLU/saturate path and the job counter.
module tb_out_writeback;

    logic          clk;
    logic          rst;
    logic          outr;
    logic [3:0]    ra;
    logic [11:0]   oa;
    logic signed [23:0] acc_d;
    logic          bias_we;
    logic [3:0]    bias_a;
    logic signed [15:0] bias_d;
    logic          relu;
    logic [3:0]    shift;
    logic [3:0]    od;
    logic [9:0]    os;
    logic          dst_we;
    logic [11:0]   dst_wa;
    logic [15:0]   dst_wd;
    logic          busy;
    logic          done;

    out_writeback dut (
        .clk     (clk),
        .rst     (rst),
        .outr    (outr),
        .ra      (ra),
        .oa      (oa),
        .acc_d   (acc_d),
        .bias_we (bias_we),
        .bias_a  (bias_a),
        .bias_d  (bias_d),
        .relu    (relu),
        .shift   (shift),
        .od      (od),
        .os      (os),
        .dst_we  (dst_we),
        .dst_wa  (dst_wa),
        .dst_wd  (dst_wd),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        int          due;
        logic [11:0] wa;
        logic [15:0] wd;
    } exp_t;

    exp_t               sb[$];
    logic signed [15:0] bias_m [16];
    logic signed [23:0] acc_pend;
    logic [11:0]        last_wa;
    logic [15:0]        last_wd;
    logic               done_exp;
    logic               mon_en;
    int                 cyc;
    int                 cnt_m;
    int                 total_m;
    int                 n_cmp;
    int                 n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic signed [23:0] acc,
                                          input logic signed [15:0] b,
                                          input int sh, input logic rl);
        longint s;
        s = longint'(acc) + longint'(b);
        s = s >>> sh;
        if (rl && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, $signed(got), $signed(exp), cyc);
        end
    endtask

    task automatic monitor();
        logic exp_we;
        exp_t e;
        if (!mon_en) return;
        exp_we = (sb.size() != 0) && (sb[0].due == cyc);
        chk("dst_we", {31'd0, dst_we}, {31'd0, exp_we});
        chk("done", {31'd0, done}, {31'd0, done_exp});
        done_exp = 1'b0;
        if (exp_we) begin
            e = sb.pop_front();
            last_wa = e.wa;
            last_wd = e.wd;
            cnt_m++;
            if (cnt_m == total_m) begin
                cnt_m    = 0;
                done_exp = 1'b1;
            end
        end
        chk("dst_wa", {20'd0, dst_wa}, {20'd0, last_wa});
        chk("dst_wd", {{16{dst_wd[15]}}, dst_wd}, {{16{last_wd[15]}}, last_wd});
    endtask

    task automatic tick(input logic o, input logic [3:0] r, input logic [11:0] a,
                        input logic signed [23:0] acc, input logic bwe, input logic [3:0] ba,
                        input logic signed [15:0] bd, input logic rv);
        exp_t e;
        @(negedge clk);
        cyc++;
        monitor();
        outr     = o;
        ra       = r;
        oa       = a;
        acc_d    = acc_pend;
        acc_pend = o ? acc : 24'sh5A5A5A;
        bias_we  = bwe;
        bias_a   = ba;
        bias_d   = bd;
        rst      = rv;
        if (!rv) begin
            sb.delete();
            cnt_m    = 0;
            done_exp = 1'b0;
            last_wa  = '0;
            last_wd  = '0;
            for (int i = 0; i < 16; i++) bias_m[i] = '0;
        end else begin
            if (bwe) bias_m[ba] = bd;
            if (o) begin
                e.due = cyc + 3;
                e.wa  = a;
                e.wd  = model(acc, bias_m[r], int'(shift), relu);
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 4'd0, 12'd0, 24'sd0, 1'b0, 4'd0, 16'sd0, 1'b1);
    endtask

    task automatic strobe(input logic [3:0] r, input logic [11:0] a, input logic signed [23:0] acc);
        tick(1'b1, r, a, acc, 1'b0, 4'd0, 16'sd0, 1'b1);
    endtask

    task automatic bias_wr(input logic [3:0] a, input logic signed [15:0] d);
        tick(1'b0, 4'd0, 12'd0, 24'sd0, 1'b1, a, d, 1'b1);
    endtask

    task automatic do_reset();
        tick(1'b0, 4'd0, 12'd0, 24'sd0, 1'b0, 4'd0, 16'sd0, 1'b0);
    endtask

    initial begin
        int r;
        rst = 1'b0; outr = 1'b0; ra = '0; oa = '0; acc_d = '0;
        bias_we = 1'b0; bias_a = '0; bias_d = '0;
        relu = 1'b0; shift = 4'd0; od = 4'd3; os = 10'd5;
        total_m = 20; acc_pend = '0; cyc = 0; cnt_m = 0; n_cmp = 0; n_bad = 0;
        done_exp = 1'b0; mon_en = 1'b0; last_wa = '0; last_wd = '0;
        for (int i = 0; i < 16; i++) bias_m[i] = '0;

        do_reset();
        mon_en = 1'b1;
        do_reset();
        idle(1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // basic path
        bias_wr(4'd2, 16'sd100);
        strobe(4'd2, 12'd5, 24'sd1000);
        idle(4);

        // saturation
        shift = 4'd4;
        strobe(4'd0, 12'd6, 24'sd8388607);
        idle(4);
        shift = 4'd0;
        strobe(4'd0, 12'd7, -24'sd8388608);
        idle(4);
        bias_wr(4'd4, -16'sd32768);
        strobe(4'd4, 12'd13, -24'sd8388608);
        idle(4);

        // ReLU and floor shift
        bias_wr(4'd3, 16'sd10);
        relu = 1'b1;
        strobe(4'd3, 12'd8, -24'sd50);
        idle(4);
        relu = 1'b0;
        strobe(4'd3, 12'd9, -24'sd50);
        idle(4);
        shift = 4'd1;
        strobe(4'd0, 12'd10, -24'sd7);
        idle(4);
        shift = 4'd0;

        // bias write in the S1 cycle of a read of the same index
        bias_wr(4'd1, 16'sd5);
        strobe(4'd1, 12'd11, 24'sd0);
        bias_wr(4'd1, 16'sd9);
        idle(2);
        strobe(4'd1, 12'd12, 24'sd0);
        idle(4);

        // job A: 20 back-to-back strobes from a clean counter
        do_reset();
        for (int c = 0; c < 4; c++) begin
            r = $urandom_range(0, 4000) - 2000;
            bias_wr(4'(c), 16'(r));
        end
        shift = 4'd3;
        relu  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            strobe(4'(k % 4), 12'(k), 24'($urandom));
            if (k == 10) chk("busy_mid", {31'd0, busy}, 32'd1);
        end
        idle(4);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("cnt_clr", {18'd0, dut.cnt}, 32'd0);
        idle(2);

        // job B, then a strobe landing in the done cycle, then a mid-job reset
        relu = 1'b1;
        for (int k = 0; k < 20; k++) strobe(4'(k % 4), 12'(100 + k), 24'($urandom));
        idle(2);
        strobe(4'd0, 12'd200, 24'($urandom));
        strobe(4'd1, 12'd201, 24'($urandom));
        chk("busy_ovl", {31'd0, busy}, 32'd1);
        for (int k = 2; k < 9; k++) strobe(4'(k % 4), 12'(200 + k), 24'($urandom));
        do_reset();
        idle(5);
        chk("busy_rst", {31'd0, busy}, 32'd0);
        chk("cnt_rst", {18'd0, dut.cnt}, 32'd0);

        // biases read back as zero after reset
        shift = 4'd0;
        relu  = 1'b0;
        for (int c = 0; c < 4; c++) strobe(4'(c), 12'(300 + c), 24'(123 - c));
        strobe(4'd15, 12'd310, -24'sd77);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
